// File: rtl/debounce_edge.sv
// debounce_edge: two-flop synchroniser, stability-count glitch filter and
// registered rise/fall pulse generation for a raw switch/button input.
// Optional build macro DEBOUNCE_TOGGLE_EN adds a push-on/push-off toggle
// register on tgl; without it tgl is tied low.
//
// state  | meaning
// -------+------------------------------------------------
// LOW    | q=0, synchronised input agrees with q
// WAIT_H | q=0, qualifying a candidate 0->1 change
// HIGH   | q=1, synchronised input agrees with q
// WAIT_L | q=1, qualifying a candidate 1->0 change
module debounce_edge #(
  parameter int N_STABLE = 4,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy,
  output logic tgl
);

  localparam logic [1:0] LOW    = 2'd0;
  localparam logic [1:0] WAIT_H = 2'd1;
  localparam logic [1:0] HIGH   = 2'd2;
  localparam logic [1:0] WAIT_L = 2'd3;

  // With a single required sample the WAIT states are skipped entirely.
  localparam bit              ONE_SHOT = (N_STABLE == 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(N_STABLE - 1);

  logic             s1, s2;
  logic [1:0]       state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             nxt_q, nxt_rise, nxt_fall;

  // Two-flop synchroniser for the asynchronous raw input.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  // Next-state, counter and output decode for the qualification FSM.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_q     = q;
    nxt_rise  = 1'b0;
    nxt_fall  = 1'b0;
    case (state)
      LOW: begin
        if (s2) begin
          if (ONE_SHOT) begin
            nxt_state = HIGH;
            nxt_q     = 1'b1;
            nxt_rise  = 1'b1;
            nxt_cnt   = '0;
          end else begin
            nxt_state = WAIT_H;
            nxt_cnt   = CNT_W'(1);
          end
        end
      end
      WAIT_H: begin
        if (!s2) begin
          nxt_state = LOW;
          nxt_cnt   = '0;
        end else if (cnt == LAST) begin
          nxt_state = HIGH;
          nxt_q     = 1'b1;
          nxt_rise  = 1'b1;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!s2) begin
          if (ONE_SHOT) begin
            nxt_state = LOW;
            nxt_q     = 1'b0;
            nxt_fall  = 1'b1;
            nxt_cnt   = '0;
          end else begin
            nxt_state = WAIT_L;
            nxt_cnt   = CNT_W'(1);
          end
        end
      end
      WAIT_L: begin
        if (s2) begin
          nxt_state = HIGH;
          nxt_cnt   = '0;
        end else if (cnt == LAST) begin
          nxt_state = LOW;
          nxt_q     = 1'b0;
          nxt_fall  = 1'b1;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + CNT_W'(1);
        end
      end
      default: begin
        nxt_state = LOW;
        nxt_cnt   = '0;
        nxt_q     = 1'b0;
      end
    endcase
  end

  // FSM state, counter and registered outputs; busy tracks the WAIT states.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= LOW;
      cnt   <= '0;
      q     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      q     <= nxt_q;
      rise  <= nxt_rise;
      fall  <= nxt_fall;
      busy  <= (nxt_state == WAIT_H) || (nxt_state == WAIT_L);
    end
  end

`ifdef DEBOUNCE_TOGGLE_EN
  logic tgl_r;

  // Push-on/push-off latch: flips on every qualified press.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) tgl_r <= 1'b0;
    else     tgl_r <= tgl_r ^ nxt_rise;
  end

  assign tgl = tgl_r;
`else
  assign tgl = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_edge.sv
// tb_debounce_edge: drives two debounce_edge instances (N_STABLE=4 and
// N_STABLE=1) with the same input and compares them against a reference
// built from a history of raw samples and a run-length rule.
module tb_debounce_edge;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       d   = 1'b0;
  logic [1:0] q_v, rise_v, fall_v, busy_v, tgl_v;

  int n_vec = 0;
  int n_err = 0;

  int nst [2] = '{4, 1};

  // reference state
  logic dq [$];
  logic mq    [2];
  logic mrise [2];
  logic mfall [2];
  logic mtgl  [2];
  int   mrun  [2];

  always #5 clk = ~clk;

  debounce_edge #(.N_STABLE(4), .CNT_W(8)) dut0 (
    .clk(clk), .clr(clr), .d(d),
    .q(q_v[0]), .rise(rise_v[0]), .fall(fall_v[0]), .busy(busy_v[0]), .tgl(tgl_v[0])
  );

  debounce_edge #(.N_STABLE(1), .CNT_W(8)) dut1 (
    .clk(clk), .clr(clr), .d(d),
    .q(q_v[1]), .rise(rise_v[1]), .fall(fall_v[1]), .busy(busy_v[1]), .tgl(tgl_v[1])
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    dq = '{1'b0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      mq[i] = 1'b0; mrise[i] = 1'b0; mfall[i] = 1'b0; mtgl[i] = 1'b0; mrun[i] = 0;
    end
  endtask

  // One clock edge of the reference: the filter sees the raw sample taken
  // two edges earlier; q follows once N consecutive seen samples disagree.
  task automatic model_edge(input logic dv);
    logic v;
    if (clr) begin
      model_reset();
      return;
    end
    v = dq[dq.size() - 2];
    dq.push_back(dv);
    if (dq.size() > 4) void'(dq.pop_front());
    for (int i = 0; i < 2; i++) begin
      mrise[i] = 1'b0;
      mfall[i] = 1'b0;
      if (v != mq[i]) mrun[i]++;
      else            mrun[i] = 0;
      if (mrun[i] == nst[i]) begin
        mq[i]   = v;
        mrise[i] = v;
        mfall[i] = ~v;
        mrun[i] = 0;
`ifdef DEBOUNCE_TOGGLE_EN
        if (v) mtgl[i] = ~mtgl[i];
`endif
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("q%0d", i),    32'(q_v[i]),    32'(mq[i]));
      check_val($sformatf("rise%0d", i), 32'(rise_v[i]), 32'(mrise[i]));
      check_val($sformatf("fall%0d", i), 32'(fall_v[i]), 32'(mfall[i]));
      check_val($sformatf("busy%0d", i), 32'(busy_v[i]), 32'(mrun[i] != 0));
      check_val($sformatf("tgl%0d", i),  32'(tgl_v[i]),  32'(mtgl[i]));
    end
  endtask

  task automatic step(input logic dv);
    d = dv;
    @(posedge clk);
    model_edge(dv);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    model_reset();

    // reset hold with d toggling
    for (int k = 0; k < 5; k++) begin
      step(k[0]);
      check_val("hold_q", 32'(q_v[0]), 32'd0);
      check_val("hold_busy", 32'(busy_v[0]), 32'd0);
      check_val("hold_state", 32'(dut0.state), 32'd0);
    end
    d = 1'b0;
    clr = 1'b0;

    // clean rise: E0 is the first sampling edge with d=1
    for (int k = 0; k <= 6; k++) begin
      step(1'b1);
      check_val("rise_busy", 32'(busy_v[0]), 32'(k >= 2 && k <= 4));
      check_val("rise_q",    32'(q_v[0]),    32'(k >= 5));
      check_val("rise_pulse", 32'(rise_v[0]), 32'(k == 5));
    end

    // clean fall
    for (int k = 0; k <= 6; k++) begin
      step(1'b0);
      check_val("fall_busy", 32'(busy_v[0]), 32'(k >= 2 && k <= 4));
      check_val("fall_q",    32'(q_v[0]),    32'(k < 5));
      check_val("fall_pulse", 32'(fall_v[0]), 32'(k == 5));
      check_val("fall_rise", 32'(rise_v[0]), 32'd0);
    end

    // glitch of three samples is rejected by N_STABLE=4
    for (int k = 0; k < 11; k++) begin
      step(k < 3);
      check_val("glitch_q",    32'(q_v[0]),    32'd0);
      check_val("glitch_rise", 32'(rise_v[0]), 32'd0);
      check_val("glitch_busy", 32'(busy_v[0]), 32'(k >= 2 && k <= 4));
    end

    // three clean presses for the toggle latch
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 8; k++) begin
        step(1'b1);
        if (k == 5) begin
          check_val("tgl_rise", 32'(rise_v[0]), 32'd1);
`ifdef DEBOUNCE_TOGGLE_EN
          check_val("tgl_seq", 32'(tgl_v[0]), 32'(p % 2 == 0));
`else
          check_val("tgl_seq", 32'(tgl_v[0]), 32'd0);
`endif
        end
      end
      for (int k = 0; k < 8; k++) step(1'b0);
    end

    // reset asserted between edges while in WAIT_H with cnt=2
    for (int k = 0; k < 4; k++) step(1'b1);
    check_val("mid_busy_pre", 32'(busy_v[0]), 32'd1);
    check_val("mid_cnt_pre",  32'(dut0.cnt),  32'd2);
    #2 clr = 1'b1;
    #1;
    check_val("mid_busy", 32'(busy_v[0]), 32'd0);
    check_val("mid_cnt",  32'(dut0.cnt),  32'd0);
    check_val("mid_q",    32'(q_v[0]),    32'd0);
    model_reset();
    @(negedge clk);
    clr = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      step(1'b1);
      check_val("post_q",    32'(q_v[0]),    32'(k >= 5));
      check_val("post_rise", 32'(rise_v[0]), 32'(k == 5));
    end

    // randomized hold lengths around the qualification threshold
    for (int n = 0; n < 300; n++) begin
      logic dv;
      int   len;
      dv  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      if ($urandom_range(0, 39) == 0) begin
        clr = 1'b1;
        step(dv);
        clr = 1'b0;
      end
      for (int k = 0; k < len; k++) step(dv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/debounce_edge.md
Name: debounce_edge

Overview:
- Conditioning stage that sits directly upstream of the single-bit D-register stage (d_syncrst).
- Takes a raw asynchronous 1-bit input (switch/button) and synchronises it through two flip-flops.
- Filters glitches with a stability counter and FSM.
- Delivers a clean level plus one-cycle rise/fall pulses for the downstream register's d/clr inputs.

Parameters:
N_STABLE, 4, consecutive synchronised samples at the new value required before the output level changes (legal range 1..2**CNT_W-1).
CNT_W, 8, stability counter width.

Ports:
clk  in  1  system clock, all state on rising edge.
clr  in  1  asynchronous, active-high reset.
d    in  1  raw asynchronous input.
q    out 1  debounced level.
rise out 1  one-cycle pulse when q goes 0->1.
fall out 1  one-cycle pulse when q goes 1->0.
busy out 1  high while a candidate change is being qualified.
tgl  out 1  toggle output (see Optional Feature).

Behaviour:
- Reset:
  - clr is asynchronous and active-high.
  - While clr=1: s1, s2, q, rise, fall, busy, tgl and the counter are 0; state=LOW.
  - Release is sampled on the next clk rising edge.
- Synchroniser: s1<=d, s2<=s1 every edge. d sampled at edge E0 is visible on s2 after E1.
- FSM states: LOW, WAIT_H, HIGH, WAIT_L.
  - LOW: s2=1 -> WAIT_H, cnt<=1; otherwise stay.
  - WAIT_H, s2=0: -> LOW, cnt<=0. Glitch is discarded; no pulse.
  - WAIT_H, s2=1 and cnt==N_STABLE-1: -> HIGH, q<=1, rise<=1, cnt<=0.
  - WAIT_H, s2=1 otherwise: cnt<=cnt+1.
  - HIGH and WAIT_L mirror LOW and WAIT_H with polarity inverted; fall is pulsed instead of rise.
- N_STABLE=1 special case: LOW with s2=1 goes directly to HIGH in one edge (q<=1, rise<=1). WAIT states are never entered.
- Latency:
  - d stable from edge E0 -> q changes at edge E(N_STABLE+1).
  - Example, N_STABLE=4: q changes at E5.
- Pulse outputs:
  - rise and fall are registered and high for exactly one cycle, coincident with the cycle q first shows its new value.
  - rise and fall are never high simultaneously.
- busy = 1 exactly in WAIT_H and WAIT_L (registered from state).
- Counter never exceeds N_STABLE-1 and never wraps.
- Glitch rule: a pulse on s2 shorter than N_STABLE cycles produces no change on q, rise or fall.
- Reset mid-qualification: all outputs and state drop to 0/LOW immediately (asynchronous). A pending rise is lost.
- Input held 1 through reset release: normal LOW->WAIT_H qualification. q rises N_STABLE+1 edges after the first edge sampling d=1 post-release.

Optional Feature:
- Macro: DEBOUNCE_TOGGLE_EN.
- Defined: tgl is a register, reset 0, inverted on the same edge that sets rise. Models a push-on/push-off latch.
- Undefined: tgl is tied to constant 0 and no toggle register is synthesised. The port list is unchanged.

Test Plan:
- Reset hold: clr=1 with d toggling for 5 cycles -> q=rise=fall=busy=tgl=0 throughout, state LOW.
- Clean rise, N_STABLE=4: clr released, d=1 sampled at E0 and held -> busy=1 from E2 to E4, q=1 and rise=1 at E5, rise=0 at E6.
- Glitch reject: d=1 for 3 cycles then 0 -> q stays 0; busy pulses high then returns to 0; no rise/fall.
- Clean fall: from q=1, d=0 held -> q=0 and fall=1 exactly 5 edges after the sampling edge; rise stays 0.
- Reset mid-operation: clr=1 asserted between clk edges during WAIT_H (cnt=2) -> busy and cnt go to 0 immediately without a clock edge; after release with d=1 held, q rises at E5 counted from the first post-release sampling edge.
- DEBOUNCE_TOGGLE_EN defined: three clean presses (d high 8 cycles, low 8 cycles) -> tgl sequence 1,0,1, each change coincident with rise. Macro undefined -> tgl=0 constantly.
